// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker:
// obs bit positions, FSM states and the golden truth table.
package gate_chk_pkg;

  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NOTB_B = 2;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 4;
  localparam int XOR_B  = 5;
  localparam int XNOR_B = 6;
  localparam int OBS_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [OBS_W-1:0] gate_expect(
    input logic a,
    input logic b
  );
    logic [OBS_W-1:0] e;
    e         = '0;
    e[AND_B]  = a & b;
    e[OR_B]   = a | b;
    e[NOTB_B] = ~b;
    e[NAND_B] = ~(a & b);
    e[NOR_B]  = ~(a | b);
    e[XOR_B]  = a ^ b;
    e[XNOR_B] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_chk_delay.sv
// LAT-deep clearable shift register aligning applied vectors
// with the model's delayed response; wire-through when LAT=0.
module gate_chk_delay #(
  parameter int LAT = 0,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (LAT == 0) begin : g_thru
    logic unused;
    assign unused = ^{clk, rst_n, clr};
    assign dout   = din;
  end else begin : g_sr
    logic [W-1:0] sr [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) sr[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < LAT; i++) sr[i] <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[LAT-1];
  end

endmodule

// File: rtl/gate_response_checker.sv
// Response monitor for the two-input gate model: compares obs to
// the golden table, counts errors, captures the first, tracks coverage.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int LAT      = 0,
  parameter int CNT_W    = 8,
  parameter int MIN_VECS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [3:0]       coverage,
  output logic [1:0]       first_err_vec,
  output logic [6:0]       first_err_mask
);

  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [2:0]       DLAST = 3'((LAT > 0) ? LAT - 1 : 0);

  state_t           state;
  logic [2:0]       dly;
  logic [2:0]       drain_cnt;
  logic [6:0]       diff;
  logic             run;
  logic             cmp;
  logic             mis;
  logic             leave_run;
  logic             done_go;
  logic [CNT_W-1:0] vec_nx;
  logic [CNT_W-1:0] err_nx;
  logic [3:0]       cov_nx;

  assign run = (state == RUN);

  gate_chk_delay #(
    .LAT (LAT),
    .W   (3)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .din   ({vec_valid & run, a, b}),
    .dout  (dly)
  );

  assign diff = gate_expect(dly[1], dly[0]) ^ obs;
  assign cmp  = dly[2] & (run | (state == DRAIN));
  assign mis  = cmp & (|diff);

  always_comb begin
    vec_nx = vec_count;
    err_nx = err_count;
    cov_nx = coverage;
    if (cmp) begin
      if (vec_count != CMAX) vec_nx = vec_count + 1'b1;
      cov_nx[dly[1:0]] = 1'b1;
    end
    if (mis && err_count != CMAX) err_nx = err_count + 1'b1;
  end

  // Auto-completion looks at the counts including this cycle's compare.
  assign leave_run = run & (stop |
    ((cov_nx == 4'hF) && (int'(vec_nx) >= MIN_VECS)));
  assign done_go = (leave_run && LAT == 0) ||
    ((state == DRAIN) && (drain_cnt == DLAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_pulse      <= 1'b0;
      err_count      <= '0;
      vec_count      <= '0;
      coverage       <= '0;
      first_err_vec  <= '0;
      first_err_mask <= '0;
      drain_cnt      <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (start) begin
        state          <= RUN;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        err_count      <= '0;
        vec_count      <= '0;
        coverage       <= '0;
        first_err_vec  <= '0;
        first_err_mask <= '0;
        drain_cnt      <= '0;
      end else begin
        if (cmp) begin
          vec_count <= vec_nx;
          err_count <= err_nx;
          coverage  <= cov_nx;
          err_pulse <= mis;
          if (mis && first_err_mask == '0) begin
            first_err_vec  <= dly[1:0];
            first_err_mask <= diff;
          end
        end
        if (done_go) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_nx == '0) && (cov_nx == 4'hF);
        end else if (leave_run) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end else if (state == DRAIN) begin
          drain_cnt <= drain_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: table vectors, corner sequences
// and a randomized run against a transaction-level reference model.
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // LAT=0 instance and CNT_W=4/MIN_VECS=20 instance share inputs
  logic       start = 0, stop = 0, vv = 0, a = 0, b = 0;
  logic [6:0] obs = '0;
  logic       busy0, done0, pass0, ep0;
  logic [7:0] errc0, vecc0;
  logic [3:0] cov0;
  logic [1:0] fv0;
  logic [6:0] fm0;
  logic       busy5, done5, pass5, ep5;
  logic [3:0] errc5, vecc5, cov5;
  logic [1:0] fv5;
  logic [6:0] fm5;

  // LAT=3 instance
  logic       start3 = 0, stop3 = 0, vv3 = 0, a3 = 0, b3 = 0;
  logic [6:0] obs3 = '0;
  logic       busy3, done3, pass3, ep3;
  logic [7:0] errc3, vecc3;
  logic [3:0] cov3;
  logic [1:0] fv3;
  logic [6:0] fm3;

  gate_response_checker #(.LAT(0), .CNT_W(8), .MIN_VECS(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .vec_valid(vv), .a(a), .b(b), .obs(obs),
    .busy(busy0), .done(done0), .pass(pass0), .err_pulse(ep0),
    .err_count(errc0), .vec_count(vecc0), .coverage(cov0),
    .first_err_vec(fv0), .first_err_mask(fm0));

  gate_response_checker #(.LAT(3), .CNT_W(8), .MIN_VECS(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stop(stop3),
    .vec_valid(vv3), .a(a3), .b(b3), .obs(obs3),
    .busy(busy3), .done(done3), .pass(pass3), .err_pulse(ep3),
    .err_count(errc3), .vec_count(vecc3), .coverage(cov3),
    .first_err_vec(fv3), .first_err_mask(fm3));

  gate_response_checker #(.LAT(0), .CNT_W(4), .MIN_VECS(20)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .vec_valid(vv), .a(a), .b(b), .obs(obs),
    .busy(busy5), .done(done5), .pass(pass5), .err_pulse(ep5),
    .err_count(errc5), .vec_count(vecc5), .coverage(cov5),
    .first_err_vec(fv5), .first_err_mask(fm5));

  logic [32:0] snap0;
  assign snap0 = {busy0, done0, pass0, ep0, errc0, vecc0,
                  cov0, fv0, fm0};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {xnor,xor,nor,nand,notb,or,and}
  function automatic logic [6:0] golden(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~y, x | y, x & y};
  endfunction

  task automatic idle_in();
    start = 0; stop = 0; vv = 0; a = 0; b = 0; obs = '0;
  endtask

  task automatic apply(input logic x, input logic y,
                       input logic [6:0] flip);
    vv = 1; a = x; b = y; obs = golden(x, y) ^ flip;
    tick();
    idle_in();
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // Reference model (LAT=0, CNT_W=8, MIN_VECS=4), one call per cycle
  int         m_st;  // 0 idle, 1 running, 2 finished
  int         m_vec, m_err;
  logic [3:0] m_cov;
  logic [1:0] m_fv;
  logic [6:0] m_fm;
  logic       m_ep;

  task automatic m_reset();
    m_st = 0; m_vec = 0; m_err = 0; m_cov = '0;
    m_fv = '0; m_fm = '0; m_ep = 0;
  endtask

  task automatic m_step();
    logic [6:0] d;
    m_ep = 0;
    if (start) begin
      m_st = 1; m_vec = 0; m_err = 0; m_cov = '0;
      m_fv = '0; m_fm = '0;
    end else if (m_st == 1) begin
      if (vv) begin
        d = golden(a, b) ^ obs;
        m_vec = (m_vec < 255) ? m_vec + 1 : 255;
        m_cov[{a, b}] = 1'b1;
        if (d != 0) begin
          m_err = (m_err < 255) ? m_err + 1 : 255;
          m_ep = 1;
          if (m_fm == 0) begin
            m_fv = {a, b};
            m_fm = d;
          end
        end
      end
      if (stop || (m_cov == 4'hF && m_vec >= 4)) m_st = 2;
    end
  endtask

  function automatic logic [32:0] m_snap();
    logic ps;
    ps = (m_st == 2) && (m_err == 0) && (m_cov == 4'hF);
    return {m_st == 1, m_st == 2, ps, m_ep, 8'(m_err), 8'(m_vec),
            m_cov, m_fv, m_fm};
  endfunction

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic [6:0] flip;
    logic       ep;
    logic       done;
  } vrec_t;

  vrec_t tv[4];
  logic [1:0] v;

  initial begin
    tv[0] = '{a: 0, b: 0, flip: 7'h00, ep: 0, done: 0};
    tv[1] = '{a: 0, b: 1, flip: 7'h00, ep: 0, done: 0};
    tv[2] = '{a: 1, b: 0, flip: 7'h00, ep: 0, done: 0};
    tv[3] = '{a: 1, b: 1, flip: 7'h00, ep: 0, done: 1};

    idle_in();
    do_reset();
    chk("reset_u0", 64'(snap0), 64'h0);
    chk("reset_u3", 64'({busy3, done3, vecc3}), 64'h0);
    chk("reset_u5", 64'({busy5, done5, vecc5}), 64'h0);

    // golden sweep, LAT=0
    do_start();
    chk("t1_busy", 64'({busy0, done0}), 64'b10);
    for (int i = 0; i < 4; i++) begin
      apply(tv[i].a, tv[i].b, tv[i].flip);
      chk("t1_ep", 64'(ep0), 64'(tv[i].ep));
      chk("t1_vec", 64'(vecc0), 64'(i + 1));
      chk("t1_done", 64'(done0), 64'(tv[i].done));
    end
    chk("t1_pass", 64'(pass0), 64'h1);
    chk("t1_err", 64'(errc0), 64'h0);
    chk("t1_cov", 64'(cov0), 64'hF);

    // single and-bit error on vector 10
    do_start();
    apply(1, 0, 7'h01);
    chk("t2_ep", 64'(ep0), 64'h1);
    chk("t2_err", 64'(errc0), 64'h1);
    chk("t2_fv", 64'(fv0), 64'b10);
    chk("t2_fm", 64'(fm0), 64'h01);
    stop = 1;
    tick();
    stop = 0;
    chk("t2_ep_once", 64'(ep0), 64'h0);
    chk("t2_done", 64'({done0, pass0}), 64'b10);

    // LAT=3: four vectors back-to-back, stop, drain
    start3 = 1;
    tick();
    start3 = 0;
    for (int c = 0; c < 8; c++) begin
      vv3 = (c < 4);
      a3 = (c < 4) ? c[1] : 1'b0;
      b3 = (c < 4) ? c[0] : 1'b0;
      stop3 = (c == 4);
      v = 2'(c - 3);
      obs3 = (c >= 3 && c < 7) ? golden(v[1], v[0]) : 7'h00;
      tick();
      if (c == 4) chk("t3_drain_busy", 64'({busy3, done3}), 64'b10);
      if (c == 6) chk("t3_drain_hold", 64'({busy3, done3}), 64'b10);
    end
    vv3 = 0; stop3 = 0; obs3 = '0;
    chk("t3_done", 64'({busy3, done3, pass3}), 64'b011);
    chk("t3_vec", 64'(vecc3), 64'h4);
    chk("t3_cov", 64'(cov3), 64'hF);

    // partial coverage then stop
    do_start();
    apply(0, 0, 7'h00);
    apply(0, 1, 7'h00);
    stop = 1;
    tick();
    stop = 0;
    chk("t4_done", 64'({done0, pass0}), 64'b10);
    chk("t4_cov", 64'(cov0), 64'b0011);
    chk("t4_err", 64'(errc0), 64'h0);

    // saturation on the 4-bit instance
    do_start();
    for (int i = 0; i < 20; i++) begin
      v = 2'(i);
      apply(v[1], v[0], 7'h40);
    end
    chk("t5_err_sat", 64'(errc5), 64'hF);
    chk("t5_vec_sat", 64'(vecc5), 64'hF);
    chk("t5_busy", 64'({busy5, done5}), 64'b10);
    stop = 1;
    tick();
    stop = 0;
    chk("t5_done", 64'({done5, pass5, errc5}), 64'h2F);

    // async reset mid-run, then restart mid-run
    do_start();
    apply(0, 0, 7'h04);
    apply(1, 1, 7'h00);
    #2 rst_n = 0;
    #1 chk("t6_async_rst", 64'(snap0), 64'h0);
    #1 rst_n = 1;
    tick();
    do_start();
    apply(0, 1, 7'h10);
    apply(1, 0, 7'h00);
    vv = 1; a = 1; b = 1; obs = 7'h7F;
    do_start();
    idle_in();
    chk("t6_restart", 64'(snap0),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 4'h0, 2'h0, 7'h0}));

    // randomized run against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 24) == 0);
      vv = ($urandom_range(0, 3) != 0);
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      obs = golden(a, b);
      if ($urandom_range(0, 5) == 0)
        obs[$urandom_range(0, 6)] ^= 1'b1;
      m_step();
      tick();
      chk("rand_u0", 64'(snap0), 64'(m_snap()));
    end
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
